booth8_seq_mult: RTL and testbench

BOOTH8_SEQ_MULT -- requirements
Module: booth8_seq_mult

---
 rtl/booth8_seq_mult.sv | 166 ++++++++++++++++
 tb/tb_booth8_seq_mult.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth8_seq_mult.sv
// booth8_seq_mult -- sequential signed multiplier that consumes pre-recoded
// radix-8 Booth digits, least-significant digit first, one per handshake.
//
// Parameters
//   N     multiplicand width (signed two's complement)
//   NDIG  radix-8 digits per operation (3*NDIG >= N+1)
//   P     product width (signed), default N+3*NDIG
//
// Ports
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         begin an operation (sampled only in IDLE)
//   multiplicand  signed A, captured when start is accepted
//   dig_valid     dig carries a valid Booth digit
//   dig           signed 4-bit Booth digit
//   dig_ready     block accepts a digit this cycle (RUN only)
//   busy          high in RUN and DONE
//   done          one-cycle pulse when product is final
//   product       signed result, held until the next operation completes
//   err           sticky illegal-digit flag
//
// Build option
//   BOOTH8_ERRCHK_EN  when defined, digits outside -4..+4 are accepted and
//                     counted but contribute 0 and set err; when undefined,
//                     every digit is used as a plain signed 4-bit value and
//                     err is tied low.

module booth8_seq_mult #(
  parameter int unsigned N    = 16,
  parameter int unsigned NDIG = 6,
  parameter int unsigned P    = N + 3 * NDIG
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [N-1:0] multiplicand,
  input  logic                dig_valid,
  input  logic        [3:0]   dig,
  output logic                dig_ready,
  output logic                busy,
  output logic                done,
  output logic signed [P-1:0] product,
  output logic                err
);

  localparam int unsigned CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic signed [P-1:0] acc;
  // Multiplicand pre-shifted by 3 bits per accepted digit, so the partial
  // product for digit i is simply dig_i * a_sh with no variable shifter.
  logic signed [P-1:0] a_sh;

  logic                xfer_c;
  logic                accept_c;
  logic signed [3:0]   dig_eff_c;
  logic signed [P-1:0] term_c;
  logic signed [P-1:0] acc_next_c;

  // dig_ready is registered and only ever high in RUN, so it doubles as the
  // RUN indicator for the handshake.
  assign xfer_c   = dig_valid & dig_ready;
  assign accept_c = (state == IDLE) & start;

`ifdef BOOTH8_ERRCHK_EN
  logic illegal_c;

  // Codes 0101..1011 (+5..+7, -8..-5) lie outside the Booth range -4..+4.
  always_comb begin
    illegal_c = 1'b0;
    dig_eff_c = signed'(dig);
    if ((dig >= 4'd5) && (dig <= 4'd11)) begin
      illegal_c = 1'b1;
      dig_eff_c = 4'sd0;
    end
  end

  // Sticky error: cleared on an accepted start, set by any illegal transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept_c) begin
      err <= 1'b0;
    end else if (xfer_c && illegal_c) begin
      err <= 1'b1;
    end
  end
`else
  always_comb begin
    dig_eff_c = signed'(dig);
  end

  assign err = 1'b0;
`endif

  // Partial product at full product width; wraps modulo 2^P like the sum.
  always_comb begin
    term_c     = a_sh * P'(dig_eff_c);
    acc_next_c = acc + term_c;
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      a_sh      <= '0;
      dig_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      product   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= RUN;
            cnt       <= '0;
            acc       <= '0;
            a_sh      <= P'(multiplicand);
            dig_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end

        RUN: begin
          if (xfer_c) begin
            acc  <= acc_next_c;
            a_sh <= a_sh <<< 3;
            cnt  <= cnt + CW'(1);
            if (cnt == LAST_IDX) begin
              state     <= DONE;
              dig_ready <= 1'b0;
              done      <= 1'b1;
              product   <= acc_next_c;
            end
          end
        end

        DONE: begin
          // Single-cycle done pulse; start is ignored here.
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          dig_ready <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth8_seq_mult.sv
// tb_booth8_seq_mult -- self-checking bench for booth8_seq_mult with default
// parameters (N=16, NDIG=6, P=34). Expected products come from plain integer
// arithmetic: A * sum(d_i * 8^i).

module tb_booth8_seq_mult;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic signed [15:0] multiplicand;
  logic               dig_valid;
  logic        [3:0]  dig;
  logic               dig_ready;
  logic               busy;
  logic               done;
  logic signed [33:0] product;
  logic               err;

  int tests = 0;
  int fails = 0;
  logic signed [33:0] last_product;

  booth8_seq_mult dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .dig_valid    (dig_valid),
    .dig          (dig),
    .dig_ready    (dig_ready),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: A * sum(d_i * 8^i), digits packed 4 bits each, d0 in [3:0].
  function automatic longint model(input longint a, input logic [23:0] ds, output bit e);
    longint sum;
    longint w;
    sum = 0;
    w   = 1;
    e   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic signed [3:0] t;
      longint v;
      t = ds[4*i +: 4];
      v = longint'(t);
`ifdef BOOTH8_ERRCHK_EN
      if (v > 4 || v < -4) begin
        v = 0;
        e = 1'b1;
      end
`endif
      sum += v * w;
      w   *= 8;
    end
    return a * sum;
  endfunction

  task automatic run_op(input string tag, input logic signed [15:0] a,
                        input logic [23:0] ds, input int stall, input bit keep_start,
                        input longint expv, input bit exp_err);
    logic signed [33:0] e34;
    e34 = 34'(expv);
    start        = 1'b1;
    multiplicand = a;
    dig_valid    = 1'b0;
    @(posedge clk); #1;
    if (!keep_start) start = 1'b0;
    multiplicand = 16'($urandom);
    check({tag, ".run_ready"}, 64'(dig_ready), 64'(1));
    check({tag, ".run_busy"}, 64'(busy), 64'(1));
    check({tag, ".run_done"}, 64'(done), 64'(0));
    check({tag, ".run_err"}, 64'(err), 64'(0));
    check({tag, ".prev_prod"}, 64'(product), 64'(last_product));
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        for (int s = 0; s < stall; s++) begin
          dig_valid    = 1'b0;
          dig          = 4'($urandom);
          multiplicand = 16'($urandom);
          @(posedge clk); #1;
          check({tag, ".stall_ready"}, 64'(dig_ready), 64'(1));
          check({tag, ".stall_done"}, 64'(done), 64'(0));
        end
      end
      dig_valid = 1'b1;
      dig       = ds[4*i +: 4];
      @(posedge clk); #1;
      dig_valid = 1'b0;
      if (i < 5) begin
        check({tag, ".mid_done"}, 64'(done), 64'(0));
        check({tag, ".mid_ready"}, 64'(dig_ready), 64'(1));
      end
    end
    check({tag, ".done"}, 64'(done), 64'(1));
    check({tag, ".done_busy"}, 64'(busy), 64'(1));
    check({tag, ".done_ready"}, 64'(dig_ready), 64'(0));
    check({tag, ".product"}, 64'(product), 64'(e34));
    check({tag, ".err"}, 64'(err), 64'(exp_err));
    last_product = e34;
    @(posedge clk); #1;
    check({tag, ".idle_done"}, 64'(done), 64'(0));
    check({tag, ".idle_busy"}, 64'(busy), 64'(0));
    check({tag, ".idle_ready"}, 64'(dig_ready), 64'(0));
    check({tag, ".idle_prod"}, 64'(product), 64'(e34));
    check({tag, ".idle_err"}, 64'(err), 64'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit               e;
    longint           m;
    logic [23:0]      ds;
    logic signed [15:0] a;
    int               v;

    rst_n        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    dig_valid    = 1'b0;
    dig          = '0;
    last_product = '0;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst.ready", 64'(dig_ready), 64'(0));
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.done", 64'(done), 64'(0));
    check("rst.product", 64'(product), 64'(0));
    check("rst.err", 64'(err), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // First start right after reset release: A=3, digits 4,4,1,0,0,0
    run_op("basic", 16'sd3, 24'h000144, 0, 1'b0, 300, 1'b0);

    // Idle with start low: nothing changes
    repeat (3) @(posedge clk);
    #1;
    check("idle.busy", 64'(busy), 64'(0));
    check("idle.product", 64'(product), 64'(last_product));

    // A=-7, digit -1 then zeros, 3-cycle stalls between transfers
    run_op("stall", -16'sd7, 24'h00000F, 3, 1'b0, 7, 1'b0);

    // Most negative multiplicand with all digits -4
    run_op("maxneg", -16'sd32768, 24'hCCCCCC, 0, 1'b0, 64'sd4908515328, 1'b0);

    // Out-of-range digit 0101 followed by 1
`ifdef BOOTH8_ERRCHK_EN
    run_op("illegal", 16'sd5, 24'h000015, 1, 1'b0, 40, 1'b1);
`else
    run_op("illegal", 16'sd5, 24'h000015, 1, 1'b0, 65, 1'b0);
`endif
    // Next start clears err (checked at RUN entry inside run_op)
    run_op("clear", 16'sd9, 24'h000001, 0, 1'b0, 9, 1'b0);

    // Reset in the middle of an operation
    start        = 1'b1;
    multiplicand = 16'sd100;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dig_valid = 1'b1;
      dig       = 4'd3;
      @(posedge clk); #1;
    end
    dig_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("midrst.ready", 64'(dig_ready), 64'(0));
    check("midrst.busy", 64'(busy), 64'(0));
    check("midrst.done", 64'(done), 64'(0));
    check("midrst.product", 64'(product), 64'(0));
    check("midrst.err", 64'(err), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_product = '0;
    @(posedge clk); #1;
    check("midrst.nodone", 64'(done), 64'(0));
    run_op("after_rst", 16'sd2, 24'h000001, 0, 1'b0, 2, 1'b0);

    // start held high through two back-to-back operations
    ds = 24'h0004C3;
    m  = model(-16'sd1234, ds, e);
    run_op("hold1", -16'sd1234, ds, 1, 1'b1, m, e);
    ds = 24'h000102;
    m  = model(16'sd777, ds, e);
    run_op("hold2", 16'sd777, ds, 0, 1'b0, m, e);

    // Randomized operations with legal digits
    for (int k = 0; k < 10; k++) begin
      a = 16'($urandom);
      for (int i = 0; i < 6; i++) begin
        v = int'($urandom_range(8)) - 4;
        ds[4*i +: 4] = 4'(v);
      end
      m = model(longint'(a), ds, e);
      run_op("rand", a, ds, int'($urandom_range(2)), 1'b0, m, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
